// File: rtl/bus_arb_mux_if.sv
// Four-master request/grant bus plus the shared slave-side bus.
// The arbiter takes the slave view; the bus masters take the master view.
interface bus_arb_mux_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              m0_req_, m1_req_, m2_req_, m3_req_;
  logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr, m3_addr;
  logic              m0_as_, m1_as_, m2_as_, m3_as_;
  logic              m0_rw, m1_rw, m2_rw, m3_rw;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
  logic              m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [ADDR_W-1:0] s_addr;
  logic              s_as_;
  logic              s_rw;
  logic [DATA_W-1:0] s_wr_data;

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_addr, m1_addr, m2_addr, m3_addr,
    input  m0_as_, m1_as_, m2_as_, m3_as_,
    input  m0_rw, m1_rw, m2_rw, m3_rw,
    input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    output s_addr, s_as_, s_rw, s_wr_data
  );

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_addr, m1_addr, m2_addr, m3_addr,
    output m0_as_, m1_as_, m2_as_, m3_as_,
    output m0_rw, m1_rw, m2_rw, m3_rw,
    output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    input  s_addr, s_as_, s_rw, s_wr_data
  );
endinterface

// File: rtl/bus_arb_mux.sv
// Four-master round-robin bus arbiter with non-preemptive ownership and a
// combinational master-to-shared-bus multiplexer driven from the owner register.
module bus_arb_mux #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  bus_arb_mux_if.slave bus,
  output logic [1:0]  owner
);

  logic [3:0]        req_n;
  logic [1:0]        owner_nxt;
  logic [1:0]        cand;
  logic              sel_req_;
  logic              sel_as_;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wr_data;

  assign req_n = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // Owner register: the only state in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 2'd0;
    end else begin
      owner <= owner_nxt;
    end
  end

  // Round-robin next owner; scanning distance 3 down to 1 lets the nearest requester win.
  always_comb begin
    owner_nxt = owner;
    cand      = owner;
    if (req_n[owner] == 1'b1) begin
      for (int i = 3; i >= 1; i--) begin
        cand = owner + 2'(i);
        if (req_n[cand] == 1'b0) begin
          owner_nxt = cand;
        end else begin
          owner_nxt = owner_nxt;
        end
      end
    end else begin
      owner_nxt = owner;
    end
  end

  // Grant decode from the owner register.
  always_comb begin
    bus.m0_grnt_ = (owner == 2'd0) ? 1'b0 : 1'b1;
    bus.m1_grnt_ = (owner == 2'd1) ? 1'b0 : 1'b1;
    bus.m2_grnt_ = (owner == 2'd2) ? 1'b0 : 1'b1;
    bus.m3_grnt_ = (owner == 2'd3) ? 1'b0 : 1'b1;
  end

  // Select the owner's bus signals.
  always_comb begin
    sel_req_    = bus.m0_req_;
    sel_as_     = bus.m0_as_;
    sel_rw      = bus.m0_rw;
    sel_addr    = bus.m0_addr;
    sel_wr_data = bus.m0_wr_data;
    case (owner)
      2'd0: begin
        sel_req_    = bus.m0_req_;
        sel_as_     = bus.m0_as_;
        sel_rw      = bus.m0_rw;
        sel_addr    = bus.m0_addr;
        sel_wr_data = bus.m0_wr_data;
      end
      2'd1: begin
        sel_req_    = bus.m1_req_;
        sel_as_     = bus.m1_as_;
        sel_rw      = bus.m1_rw;
        sel_addr    = bus.m1_addr;
        sel_wr_data = bus.m1_wr_data;
      end
      2'd2: begin
        sel_req_    = bus.m2_req_;
        sel_as_     = bus.m2_as_;
        sel_rw      = bus.m2_rw;
        sel_addr    = bus.m2_addr;
        sel_wr_data = bus.m2_wr_data;
      end
      2'd3: begin
        sel_req_    = bus.m3_req_;
        sel_as_     = bus.m3_as_;
        sel_rw      = bus.m3_rw;
        sel_addr    = bus.m3_addr;
        sel_wr_data = bus.m3_wr_data;
      end
      default: begin
        sel_req_    = 1'b1;
        sel_as_     = 1'b1;
        sel_rw      = 1'b1;
        sel_addr    = '0;
        sel_wr_data = '0;
      end
    endcase
  end

  // Shared bus drive; a parked owner that is not requesting may not strobe.
  always_comb begin
    bus.s_addr    = sel_addr;
    bus.s_rw      = sel_rw;
    bus.s_wr_data = sel_wr_data;
    if (sel_req_ == 1'b1) begin
      bus.s_as_ = 1'b1;
    end else begin
      bus.s_as_ = sel_as_;
    end
  end

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Four-master round-robin bus arbiter and master-side multiplexer for the shared system bus. It sits directly downstream of each CPU bus interface (and any other bus master): it consumes their active-low bus requests, returns active-low grants, and forwards the granted master's address, strobe, direction and write data onto the shared slave-side bus. Ownership is held until the owner releases its request. There is no preemption, so a master's request/access/ready sequence is never broken.

## Interface

Parameters:
- ADDR_W, 30, word-address width; matches the word address bus.
- DATA_W, 32, data width; matches the word data bus.

Ports:
- clk  in  1  system clock; everything samples on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_req_  in  1  bus request from master N (N = 0..3), active-low.
- mN_addr  in  ADDR_W  master N word address.
- mN_as_  in  1  master N address strobe, active-low.
- mN_rw  in  1  master N direction, 1 = READ, 0 = WRITE.
- mN_wr_data  in  DATA_W  master N write data.
- mN_grnt_  out  1  grant to master N, active-low; exactly one is low at all times.
- s_addr  out  ADDR_W  shared bus address.
- s_as_  out  1  shared bus address strobe, active-low.
- s_rw  out  1  shared bus direction.
- s_wr_data  out  DATA_W  shared bus write data.
- owner  out  2  index of the current bus owner.

## Operation

- State is a single 2-bit register, owner, which is the only sequential element.
- mN_grnt_ is decoded combinationally from owner: mN_grnt_ = 0 if owner == N, otherwise 1.
- Arbitration is evaluated every cycle.
  - If req_ of the current owner is low (0), owner is unchanged (hold).
  - If req_ of the current owner is high (1), the next owner is the first master with req_ low, searching owner+1, owner+2, owner+3 modulo 4.
  - If no master requests, owner is unchanged (parking).
- Rotation wraps from 3 to 0. Simultaneous requests are resolved purely by rotation distance from the current owner. Master index priority is never used.
- Shared-bus mux is combinational from owner: s_addr, s_as_, s_rw and s_wr_data equal the owner's mN_addr, mN_as_, mN_rw and mN_wr_data.
- If the owner is parked with its req_ high, s_as_ is forced to 1 (inactive), so a parked non-requesting master can never strobe the bus.
- A non-owner's as_ is ignored entirely.
- Reset values:
  - owner = 0.
  - m0_grnt_ = 0; m1_grnt_, m2_grnt_ and m3_grnt_ = 1.
  - s_as_ = 1, because m0_req_ is assumed high after reset; otherwise s_as_ = m0_as_.
  - s_addr, s_rw and s_wr_data follow master 0.
- Reset asserted mid-transfer: owner returns to 0 on that edge, whatever the current owner and request state. The interrupted master's grant drops in the same cycle.

## Timing

- Grant latency is 1 cycle. If req_ is sampled low at edge k while the bus is free (or the requester already owns it), the grant is low after edge k+1.
- With the CPU interface:
  - Request is registered at edge T.
  - Grant is seen at T+1.
  - Strobe is asserted at T+2.
  - Strobe passes through the mux combinationally (zero latency).
- Handover: the owner releases req_ at edge k, and the new owner's grant is low after edge k+1. There is no idle gap beyond that cycle and there is never overlap: exactly one grant is low in every cycle.
- A master that releases req_ and re-asserts it at the very next edge loses the bus if any other master requested in the release cycle. Otherwise it keeps the bus (parking).
- Grant outputs and the mux are glitch-free relative to clk because both derive only from the owner register plus mN_req_ (s_as_ gating) and the mux inputs.

## Test plan

- **Reset:** hold reset high for 3 cycles with all req_ = 1 -> owner = 0, m0_grnt_ = 0, other grants = 1, s_as_ = 1. Then drive m0_req_ = 0, m0_as_ = 0, m0_addr = 0x1000 -> s_addr = 0x1000 and s_as_ = 0 in the same cycle.
- **Single request:** m2_req_ = 0 from idle (owner 0) -> m2_grnt_ = 0 and owner = 2 one cycle later. Hold m2_req_ low for 10 cycles while m1_req_ = 0 -> owner stays 2 throughout.
- **Rotation:** m0, m1, m2 and m3 all request with owner = 1. Then owner releases one cycle after each grant -> grant order 2, 3, 0, 1, with owner wrapping 3 -> 0.
- **Mux isolation:** owner = 3 with m3_as_ = 1 and m1_as_ = 0, m1_addr = 0x3FFFFFFF -> s_as_ = 1 and s_addr = m3_addr. Then m3_wr_data = 0xDEADBEEF with m3_rw = 0 -> s_wr_data = 0xDEADBEEF and s_rw = 0.
- **Simultaneous release and request:** owner 1 releases while m0 and m3 request in the same cycle -> owner = 3 next cycle (rotation distance 2 beats distance 3).
- **Reset mid-transfer:** owner = 2 with m2_req_ held low; assert reset for 1 cycle -> owner = 0 and m2_grnt_ = 1 after that edge. After reset releases with m2_req_ still low and m0_req_ = 1 -> owner = 2 one cycle later.
